// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported memory between instruction fetch and load/store.
// Data wins ties; a saturating starvation counter forces a fetch grant after STARVE data grants.
module mem_arbiter #(
    parameter int unsigned n      = 32,
    parameter int unsigned STARVE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_req,
    input  logic [n-1:0] i_addr,
    output logic         i_ack,
    output logic [n-1:0] i_rdata,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [n-1:0] d_addr,
    input  logic [n-1:0] d_wdata,
    output logic         d_ack,
    output logic [n-1:0] d_rdata,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [n-1:0] mem_rdata,
    output logic         stall
);
    typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE);

    state_e       state_q, state_d;
    logic [3:0]   starve_q, starve_d;
    logic         i_ack_q, i_ack_d;
    logic         d_ack_q, d_ack_d;
    logic [n-1:0] i_rdata_q, i_rdata_d;
    logic [n-1:0] d_rdata_q, d_rdata_d;
    logic         we_q, we_d;
    logic [n-1:0] addr_q, addr_d;
    logic [n-1:0] wdata_q, wdata_d;
    logic         i_live, d_live;

    // A requester is ignored in its own ack cycle so a request dropped on ack is never re-granted.
    assign i_live = i_req & ~i_ack_q;
    assign d_live = d_req & ~d_ack_q;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (d_live && !(i_live && starve_q == StarveMax)) begin
                    state_d = StGrantD;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    if (i_req && starve_q != StarveMax) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (i_live) begin
                    state_d  = StGrantI;
                    we_d     = 1'b0;
                    addr_d   = i_addr;
                    starve_d = 4'd0;
                end
            end
            StGrantI: begin
                if (mem_ready) begin
                    state_d   = StIdle;
                    i_ack_d   = 1'b1;
                    i_rdata_d = mem_rdata;
                end
            end
            StGrantD: begin
                if (mem_ready) begin
                    state_d = StIdle;
                    d_ack_d = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            starve_q  <= 4'd0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Decoded from the async-reset state register, so it drops as soon as reset asserts.
    assign mem_req   = (state_q != StIdle);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall     = i_req & ~i_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected read data is queued at request time and
// popped when the matching ack appears; per-scenario tasks check timing and grant order.
module tb_mem_arbiter;
    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;

    mem_arbiter #(.n(32), .STARVE(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Memory model: fixed address pattern until written, configurable wait states.
    logic        ready_tie;
    int          waits;
    int          wcnt = 0;
    logic [31:0] mdat [0:255];
    logic [255:0] mval = '0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {22'b0, a[9:2], 2'b00} ^ 32'h0C0D_000B;
    endfunction

    assign mem_ready = ready_tie | (mem_req && wcnt == waits);
    assign mem_rdata = mval[mem_addr[9:2]] ? mdat[mem_addr[9:2]] : pat(mem_addr);

    always @(posedge clk) begin
        if (!mem_req || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (mem_req && mem_ready && mem_we) begin
            mdat[mem_addr[9:2]] <= mem_wdata;
            mval[mem_addr[9:2]] <= 1'b1;
        end
    end

    // Bench-side expectation of memory contents, updated when a store is issued.
    logic [31:0]  shadow [0:255];
    logic [255:0] shadow_v = '0;
    logic [31:0]  d_last = 32'h0;

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return shadow_v[a[9:2]] ? shadow[a[9:2]] : pat(a);
    endfunction

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    bit          grants[$];  // 1 = fetch grant

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: pops expected data on each ack and logs each grant.
    initial begin
        logic [31:0] e;
        logic        req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (i_ack) begin
                    n_cmp++;
                    if (exp_i.size() == 0) begin
                        n_bad++;
                        $display("FAIL i_ack_unexpected: got ack rdata=%h, required no ack", i_rdata);
                    end else begin
                        e = exp_i.pop_front();
                        if (i_rdata !== e) begin
                            n_bad++;
                            $display("FAIL i_rdata: got %h, required %h", i_rdata, e);
                        end
                    end
                end
                if (d_ack) begin
                    n_cmp++;
                    if (exp_d.size() == 0) begin
                        n_bad++;
                        $display("FAIL d_ack_unexpected: got ack rdata=%h, required no ack", d_rdata);
                    end else begin
                        e = exp_d.pop_front();
                        if (d_rdata !== e) begin
                            n_bad++;
                            $display("FAIL d_rdata: got %h, required %h", d_rdata, e);
                        end
                    end
                end
                if (mem_req && !req_prev) grants.push_back(mem_addr >= 32'h1000);
            end
            req_prev = mem_req;
        end
    end

    // Drives one request, waits for its ack, then drops req one edge after the ack.
    task automatic issue(input bit side, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat);
        logic [31:0] e;
        bit          got;
        if (side) begin
            if (we) begin
                e = d_last;
                shadow[addr[9:2]] = wd;
                shadow_v[addr[9:2]] = 1'b1;
            end else begin
                e = exp_word(addr);
                d_last = e;
            end
            exp_d.push_back(e);
            d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        end else begin
            exp_i.push_back(exp_word(addr));
            i_addr = addr; i_req = 1'b1;
        end
        lat = 0;
        got = 1'b0;
        while (lat < 50 && !got) begin
            @(posedge clk); #1;
            lat++;
            got = side ? d_ack : i_ack;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout side=%0d addr=%h: got no ack in %0d cycles, required ack",
                     side, addr, lat);
        end
        @(posedge clk); #1;
        if (side) d_req = 1'b0;
        else i_req = 1'b0;
    endtask

    task automatic test_reset();
        int busy;
        reset = 1'b0; i_req = 1'b1; d_req = 1'b1; ready_tie = 1'b1;
        #3;
        n_cmp++;
        if ({i_ack, d_ack, mem_req, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b%b req=%b we=%b addr=%h wd=%h ir=%h dr=%h, required all 0",
                     i_ack, d_ack, mem_req, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL reset_stall: got %b, required 1", stall);
        end
        @(negedge clk);
        d_req = 1'b0; i_addr = 32'h0000_0004;
        exp_i.push_back(32'h0C0D_000F);
        reset = 1'b1;
        d_last = 32'h0;
        @(posedge clk); #1;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            n_bad++; $display("FAIL first_grant: got req=%b addr=%h, required 1 / 00000004", mem_req, mem_addr);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (i_ack !== 1'b1) begin
            n_bad++; $display("FAIL first_ack: got i_ack=%b, required 1", i_ack);
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        ready_tie = 1'b0;
        busy = 0;
        repeat (3) begin
            if (mem_req || i_ack) busy++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (busy != 0) begin
            n_bad++; $display("FAIL reset_no_regrant: got %0d busy cycles, required 0", busy);
        end
    endtask

    task automatic test_store_load();
        int  lat;
        int  pulses;
        bit  seen;
        d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A5_A5A5; d_req = 1'b1;
        exp_d.push_back(d_last);
        shadow[8'h10] = 32'hA5A5_A5A5; shadow_v[8'h10] = 1'b1;
        seen = 1'b0; pulses = 0; lat = 0;
        while (lat < 20 && pulses == 0) begin
            @(posedge clk); #1; lat++;
            if (mem_req && !seen) begin
                seen = 1'b1;
                n_cmp++;
                if (mem_we !== 1'b1 || mem_wdata !== 32'hA5A5_A5A5 || mem_addr !== 32'h40) begin
                    n_bad++;
                    $display("FAIL store_port: got we=%b wd=%h addr=%h, required 1/a5a5a5a5/00000040",
                             mem_we, mem_wdata, mem_addr);
                end
            end
            if (d_ack) pulses++;
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        if (d_ack) pulses++;
        @(posedge clk); #1;
        if (d_ack) pulses++;
        n_cmp++;
        if (pulses != 1 || !seen) begin
            n_bad++; $display("FAIL store_ack_pulses: got %0d (grant seen %b), required 1", pulses, seen);
        end
        issue(1'b1, 1'b0, 32'h40, 32'h0, lat);
        n_cmp++;
        if (lat != 2) begin
            n_bad++; $display("FAIL load_latency: got %0d, required 2", lat);
        end
    endtask

    task automatic test_wait_states();
        int cnt, lat;
        bit bad_addr, bad_stall;
        waits = 3;
        exp_i.push_back(exp_word(32'h1010));
        i_addr = 32'h1010; i_req = 1'b1;
        cnt = 0; lat = 0; bad_addr = 1'b0; bad_stall = 1'b0;
        while (lat < 20) begin
            @(posedge clk); #1; lat++;
            if (lat == 1) i_addr = 32'h2222;
            if (mem_req) begin
                cnt++;
                if (mem_addr !== 32'h1010) bad_addr = 1'b1;
            end
            if (i_ack) begin
                if (stall) bad_stall = 1'b1;
                break;
            end
            if (!stall) bad_stall = 1'b1;
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        waits = 0;
        n_cmp++;
        if (cnt != 4) begin
            n_bad++; $display("FAIL wait_req_cycles: got %0d, required 4", cnt);
        end
        n_cmp++;
        if (lat != 5) begin
            n_bad++; $display("FAIL wait_latency: got %0d, required 5", lat);
        end
        n_cmp++;
        if (bad_addr || bad_stall) begin
            n_bad++; $display("FAIL wait_stable: got addr_bad=%b stall_bad=%b, required 0/0", bad_addr, bad_stall);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int k = 0; k < 6; k++) begin
            issue(1'b1, (k < 3), 32'h200 + 32'(4 * (k % 3)), 32'h1234_0000 + 32'(k * 7), lat);
            n_cmp++;
            if (lat != 2) begin
                n_bad++; $display("FAIL b2b_latency k=%0d: got %0d, required 2", k, lat);
            end
        end
    endtask

    task automatic test_req_drop();
        int lat, busy;
        issue(1'b1, 1'b0, 32'h2C, 32'h0, lat);
        busy = 0;
        repeat (3) begin
            if (mem_req || d_ack) busy++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (busy != 0) begin
            n_bad++; $display("FAIL drop_no_regrant: got %0d busy cycles, required 0", busy);
        end
    endtask

    task automatic test_contention();
        int i_lat, i_pos;
        grants.delete();
        i_pos = 0; i_lat = 0;
        @(negedge clk);
        fork
            begin
                int l;
                for (int k = 0; k < 6; k++)
                    issue(1'b1, k[0], 32'h100 + 32'(4 * k), 32'hBEEF_0000 + 32'(k), l);
            end
            begin
                int l;
                issue(1'b0, 1'b0, 32'h1000, 32'h0, i_lat);
                i_pos = grants.size();
                issue(1'b0, 1'b0, 32'h1004, 32'h0, l);
            end
        join
        n_cmp++;
        if (grants.size() == 0 || grants[0] !== 1'b0) begin
            n_bad++; $display("FAIL tie_first_grant: got size=%0d, required first grant data", grants.size());
        end
        n_cmp++;
        if (i_pos < 1 || i_pos > 5) begin
            n_bad++; $display("FAIL fetch_progress: got fetch at grant %0d, required 1..5", i_pos);
        end
        n_cmp++;
        if (i_lat > 10) begin
            n_bad++; $display("FAIL fetch_latency: got %0d, required <= 10", i_lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, acks;
        waits = 10;
        d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++; $display("FAIL mid_grant: got mem_req=%b, required 1", mem_req);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++; $display("FAIL async_drop: got mem_req=%b, required 0", mem_req);
        end
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        d_last = 32'h0;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (d_ack || mem_req) acks++;
        end
        n_cmp++;
        if (acks != 0) begin
            n_bad++; $display("FAIL mid_no_ack: got %0d ack/req cycles, required 0", acks);
        end
        waits = 0;
        issue(1'b1, 1'b0, 32'h80, 32'h0, lat);
        n_cmp++;
        if (lat != 2) begin
            n_bad++; $display("FAIL rereq_latency: got %0d, required 2", lat);
        end
    endtask

    initial begin
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; ready_tie = 1'b0; waits = 0;
        test_reset();
        test_store_load();
        test_wait_states();
        test_back_to_back();
        test_req_drop();
        test_contention();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_i.size() != 0 || exp_d.size() != 0) begin
            n_bad++;
            $display("FAIL pending_acks: got %0d fetch / %0d data outstanding, required 0 / 0",
                     exp_i.size(), exp_d.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, required finish");
        $fatal(1, "timeout");
    end
endmodule
